// File: rtl/boot_loader.sv
// Byte-stream program loader: takes a length-prefixed little-endian image,
// writes it word by word into instruction memory, then releases the core from reset.

module boot_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state;
  logic [15:0]       n;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] widx;
  logic [2:0][7:0]   lane;
  logic [2:0]        lane_we;
  logic              acc;
  logic [15:0]       n_full;
  logic              last;

  assign acc    = in_valid && in_ready;
  assign n_full = {in_data, n[7:0]};
  assign last   = 16'(widx) == (n - 16'd1);

  // Lanes 0..2 are buffered; lane 3 is taken straight from in_data on the write.
  assign lane_we = (acc && state == S_DATA) ? (3'b001 << cnt) : 3'b000;

  boot_lane u_lane [2:0] (
    .clk (clk),
    .rst (rst),
    .we  (lane_we),
    .d   ({3{in_data}}),
    .q   (lane)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HDR0;
      n         <= '0;
      cnt       <= '0;
      widx      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      in_ready <= (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
      case (state)
        S_HDR0: if (acc) begin
          n[7:0] <= in_data;
          state  <= S_HDR1;
        end
        S_HDR1: if (acc) begin
          n[15:8] <= in_data;
          if (n_full == 16'd0) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else if (32'(n_full) > 32'(DEPTH)) begin
            state    <= S_ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (acc) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            mem_we    <= 1'b1;
            mem_addr  <= widx;
            mem_wdata <= {in_data, lane};
            widx      <= widx + 1'b1;
            if (last) begin
              state    <= S_FIN;
              in_ready <= 1'b0;
            end
          end
        end
        // FIN is the final write's mem_we cycle; release follows at this edge.
        S_FIN: begin
          state    <= S_DONE;
          core_rst <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: header decode, word assembly, stalls,
// zero length, overflow, mid-word reset and full-depth load.

module tb_boot_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] wadr_q[$];
  logic [31:0] wdat_q[$];

  boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wadr_q.push_back(32'(mem_addr));
      wdat_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int bad;
    logic [15:0] wi;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata",    mem_wdata,     32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic load
    base = wadr_q.size();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
    chk("b_we0",   32'(mem_we),   32'd1);
    chk("b_addr0", 32'(mem_addr), 32'd0);
    chk("b_data0", mem_wdata,     32'h00100513);
    send(8'h93, 0);
    chk("b_we_gap", 32'(mem_we), 32'd0);
    send(8'h05, 0); send(8'h20, 0);
    chk("b_core_rst_hold", 32'(core_rst), 32'd1);
    send(8'h00, 0);
    chk("b_we1",   32'(mem_we),   32'd1);
    chk("b_addr1", 32'(mem_addr), 32'd1);
    chk("b_data1", mem_wdata,     32'h00200593);
    chk("b_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("b_done",     32'(done),     32'd1);
    chk("b_core_rst", 32'(core_rst), 32'd0);
    chk("b_we_off",   32'(mem_we),   32'd0);
    chk("b_in_ready", 32'(in_ready), 32'd0);
    chk("b_nwrites",  32'(wadr_q.size() - base), 32'd2);

    // Stalls
    do_reset();
    base = wadr_q.size();
    send(8'h02, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h13, $urandom_range(0, 3)); send(8'h05, $urandom_range(0, 3));
    send(8'h10, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
    send(8'h93, $urandom_range(1, 3)); send(8'h05, $urandom_range(1, 3));
    send(8'h20, $urandom_range(1, 3)); send(8'h00, $urandom_range(1, 3));
    @(negedge clk);
    chk("s_done",    32'(done), 32'd1);
    chk("s_nwrites", 32'(wadr_q.size() - base), 32'd2);
    if (wadr_q.size() - base == 2) begin
      chk("s_addr0", wadr_q[base],   32'd0);
      chk("s_data0", wdat_q[base],   32'h00100513);
      chk("s_addr1", wadr_q[base+1], 32'd1);
      chk("s_data1", wdat_q[base+1], 32'h00200593);
    end

    // Zero length
    do_reset();
    base = wadr_q.size();
    send(8'h00, 0); send(8'h00, 0);
    chk("z_done",     32'(done),     32'd1);
    chk("z_core_rst", 32'(core_rst), 32'd0);
    chk("z_in_ready", 32'(in_ready), 32'd0);
    chk("z_mem_we",   32'(mem_we),   32'd0);
    @(negedge clk);
    chk("z_nwrites",  32'(wadr_q.size() - base), 32'd0);

    // Overflow: N = 1025
    do_reset();
    base = wadr_q.size();
    send(8'h01, 0); send(8'h04, 0);
    chk("o_err",      32'(err),      32'd1);
    chk("o_core_rst", 32'(core_rst), 32'd1);
    chk("o_in_ready", 32'(in_ready), 32'd0);
    chk("o_done",     32'(done),     32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("o_err_hold", 32'(err), 32'd1);
    chk("o_nwrites",  32'(wadr_q.size() - base), 32'd0);

    // Reset mid-word; byte presented during reset must be dropped
    do_reset();
    send(8'h01, 0); send(8'h00, 0); send(8'h13, 0); send(8'h05, 0);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    chk("m_in_ready", 32'(in_ready), 32'd0);
    chk("m_core_rst", 32'(core_rst), 32'd1);
    chk("m_mem_we",   32'(mem_we),   32'd0);
    chk("m_done",     32'(done),     32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    chk("m_we",   32'(mem_we),   32'd1);
    chk("m_addr", 32'(mem_addr), 32'd0);
    chk("m_data", mem_wdata,     32'hDEADBEEF);
    @(negedge clk);
    chk("m_done_after", 32'(done), 32'd1);

    // Full depth: N = 1024, word i = i
    do_reset();
    base = wadr_q.size();
    send(8'h00, 0); send(8'h04, 0);
    for (int i = 0; i < DEPTH; i++) begin
      wi = 16'(i);
      send(wi[7:0], 0); send(wi[15:8], 0); send(8'h00, 0); send(8'h00, 0);
    end
    chk("f_we_last",   32'(mem_we),   32'd1);
    chk("f_addr_last", 32'(mem_addr), 32'd1023);
    chk("f_data_last", mem_wdata,     32'h000003FF);
    @(negedge clk);
    chk("f_done",     32'(done),     32'd1);
    chk("f_core_rst", 32'(core_rst), 32'd0);
    chk("f_nwrites",  32'(wadr_q.size() - base), 32'd1024);
    bad = 0;
    if (wadr_q.size() - base == 1024)
      for (int i = 0; i < DEPTH; i++)
        if (wadr_q[base+i] !== 32'(i) || wdat_q[base+i] !== 32'(i)) bad++;
    chk("f_seq_bad", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
# boot_loader

Program-image loader that sits upstream of the `riscv` core and its instruction memory in the SoC. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory. It holds the core in reset until the image is fully written, then releases it.

## Interface
Parameters:
- `DEPTH`, 1024: instruction memory size in 32-bit words.
- `ADDR_W`, 10: word-address width; `2**ADDR_W` >= `DEPTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the current write.
- `mem_wdata`  out  32  word being written.
- `core_rst`  out  1  active-high reset to the core (drives `riscv.rst`).
- `done`  out  1  image loaded; core released.
- `err`  out  1  header length exceeded `DEPTH`; core held in reset.

## Operation
- A byte is transferred on any rising edge where `in_valid && in_ready`.
- Stream format: 2-byte little-endian word count N (byte0 = N[7:0], byte1 = N[15:8]), followed by 4*N data bytes, each word little-endian (first byte = bits 7:0).
- FSM states and transitions:
  - HDR0 captures N[7:0] and goes to HDR1.
  - HDR1 captures N[15:8], then:
    - N == 0 goes to DONE.
    - N > DEPTH goes to ERR.
    - Otherwise goes to DATA.
  - DATA: a 2-bit byte counter selects the lane. On the 4th byte the word is complete and the write is issued.
    - If it was word N-1, the next state is FIN.
    - Otherwise the FSM stays in DATA.
  - FIN: a single cycle in which the final write is committed, then DONE.
  - DONE and ERR are terminal until reset.
- `in_ready` = 1 in HDR0, HDR1 and DATA. It is 0 in FIN, DONE and ERR, and while `rst` is low.
- Write addresses run 0, 1, …, N-1 with no wrap. N ≤ DEPTH is guaranteed by the ERR check.
- Bytes presented after the last data byte are not accepted (`in_ready` = 0).
- Stalls: if `in_valid` is low, nothing changes. Partial-word lanes are retained indefinitely.

## Timing
- All outputs are registered.
- Reset values (while `rst` = 0 at an edge and the cycle after):
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `core_rst` = 1, `done` = 0, `err` = 0.
  - State = HDR0.
- First cycle after `rst` rises: `in_ready` = 1.
- Write latency: the 4th byte of word k is accepted at edge E. During the cycle after E:
  - `mem_we` = 1.
  - `mem_addr` = k.
  - `mem_wdata` = the assembled word.
  
  `mem_we` is low in all other cycles. Back-to-back words can therefore produce `mem_we` at most once every 4 cycles.
- Release: for the final word, FIN coincides with its `mem_we` cycle. At the next edge, `core_rst` falls to 0 and `done` rises to 1 together.
- N == 0: the edge that accepts header byte1 moves to DONE. `core_rst` = 0 and `done` = 1 from the next cycle. There is no `mem_we`.
- ERR: `err` = 1 from the cycle after header byte1 is accepted. `core_rst` stays 1 and there is no `mem_we`.
- Reset mid-operation (`rst` low at any edge, in any state):
  - Return to HDR0.
  - Discard the byte counter, partial word and N.
  - Force `core_rst` = 1 and clear `done`/`err`.
  - A write pending for the next cycle is cancelled (`mem_we` = 0).
- A byte presented with `in_valid` on the same edge that `rst` is low is not accepted.

## Test plan
- **Basic load:** send header 02 00, then bytes 13 05 10 00 93 05 20 00. Required response:
  - `mem_we` pulses at addr 0 with 0x00100513, then at addr 1 with 0x00200593.
  - `core_rst` falls, and `done` rises, exactly 1 cycle after the second `mem_we`.
- **Stalls:** same image with `in_valid` toggled randomly. Required response: identical writes and data, and `mem_we` only one cycle per word.
- **Zero length:** header 00 00. Required response: no `mem_we`, `done` = 1 and `core_rst` = 0 one cycle after byte1, then `in_ready` = 0.
- **Overflow:** header 01 04 (N = 1025, DEPTH = 1024). Required response: `err` = 1, `core_rst` stays 1, `in_ready` = 0, and no writes.
- **Reset mid-word:** after header 01 00 and 2 data bytes, pull `rst` low for 1 cycle. Required response:
  - Outputs return to reset values.
  - A new stream 01 00 EF BE AD DE writes 0xDEADBEEF at addr 0, then `done` = 1.
- **Full depth:** N = 1024 with word i = i. Required response: 1024 writes with the last at addr 1023 = 0x000003FF, no address wrap, and `done` after the last write.
